// File: rtl/mem_read_arbiter.sv
// Arbitrates NCLIENT cache read requests onto one block-read port; one read outstanding at a time.
// Optional feature macro: MEMARB_ROUND_ROBIN_EN (rotating priority); undefined = fixed lowest-index priority.
module mem_read_arbiter #(
  parameter int NCLIENT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCLIENT-1:0]       creqcyc,
  input  logic [NCLIENT-1:0][63:0] caddr,
  output logic [NCLIENT-1:0]       crespcyc,
  output logic [0:511]             cdata,
  output logic                     memrdreqcyc,
  output logic [63:0]              memrdaddr,
  input  logic                     memrdrespcyc,
  input  logic [0:511]             memrddata,
  output logic [1:0]               dbg_state_o
);

  localparam int WW = $clog2(NCLIENT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Handshake: a client holds creqcyc until its one-cycle crespcyc strobe; the arbiter holds
  // memrdreqcyc/memrdaddr until it samples memrdrespcyc, and ignores that strobe outside BUSY.
  state_t              state_q;
  logic [WW-1:0]       winner_q;
  logic [NCLIENT-1:0]  crespcyc_q;
  logic [0:511]        cdata_q;
  logic                memrdreqcyc_q;
  logic [63:0]         memrdaddr_q;

  logic                grant_vld;
  logic [WW-1:0]       grant_idx;
  logic [NCLIENT-1:0]  winner_onehot;

`ifdef MEMARB_ROUND_ROBIN_EN
  logic [WW-1:0]       ptr_q;
  logic [WW-1:0]       ptr_d;

  // Winner is the requester at the smallest ascending distance from the pointer, with wrap.
  always_comb begin
    int best_d;
    int d;
    best_d    = NCLIENT;
    d         = 0;
    grant_vld = |creqcyc;
    grant_idx = '0;
    for (int j = 0; j < NCLIENT; j++) begin
      if (creqcyc[j]) begin
        d = (j - int'(ptr_q) + NCLIENT) % NCLIENT;
        if (d < best_d) begin
          best_d    = d;
          grant_idx = WW'(j);
        end
      end
    end
    ptr_d = WW'((int'(grant_idx) + 1) % NCLIENT);
  end
`else
  always_comb begin
    grant_vld = |creqcyc;
    grant_idx = '0;
    for (int j = NCLIENT - 1; j >= 0; j--) begin
      if (creqcyc[j]) grant_idx = WW'(j);
    end
  end
`endif

  assign winner_onehot = {{(NCLIENT-1){1'b0}}, 1'b1} << winner_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      winner_q      <= '0;
      crespcyc_q    <= '0;
      cdata_q       <= '0;
      memrdreqcyc_q <= 1'b0;
      memrdaddr_q   <= '0;
`ifdef MEMARB_ROUND_ROBIN_EN
      ptr_q         <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          crespcyc_q <= '0;
          if (grant_vld) begin
            winner_q      <= grant_idx;
            memrdaddr_q   <= {caddr[grant_idx][63:6], 6'b0};
            memrdreqcyc_q <= 1'b1;
            state_q       <= BUSY;
`ifdef MEMARB_ROUND_ROBIN_EN
            ptr_q         <= ptr_d;
`endif
          end
        end
        BUSY: begin
          // The winner may have dropped its request by now; the strobe still goes to it.
          if (memrdrespcyc) begin
            cdata_q       <= memrddata;
            memrdreqcyc_q <= 1'b0;
            crespcyc_q    <= winner_onehot;
            state_q       <= RESP;
          end
        end
        RESP: begin
          crespcyc_q <= '0;
          state_q    <= IDLE;
        end
        default: begin
          crespcyc_q    <= '0;
          memrdreqcyc_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign crespcyc    = crespcyc_q;
  assign cdata       = cdata_q;
  assign memrdreqcyc = memrdreqcyc_q;
  assign memrdaddr   = memrdaddr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: a 2-client and a 4-client instance on one clock.
// Expectations follow MEMARB_ROUND_ROBIN_EN when the bench is built with it defined.
module tb_mem_read_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 2-client instance
  logic [1:0]       creq2;
  logic [1:0][63:0] caddr2;
  logic [1:0]       cresp2;
  logic [0:511]     cdata2;
  logic             mreq2;
  logic [63:0]      maddr2;
  logic             mresp2;
  logic [0:511]     mdata2;
  logic [1:0]       st2;

  // 4-client instance
  logic [3:0]       creq4;
  logic [3:0][63:0] caddr4;
  logic [3:0]       cresp4;
  logic [0:511]     cdata4;
  logic             mreq4;
  logic [63:0]      maddr4;
  logic             mresp4;
  logic [0:511]     mdata4;
  logic [1:0]       st4;

  mem_read_arbiter #(.NCLIENT(2)) u_dut2 (
    .clk(clk), .reset(reset), .creqcyc(creq2), .caddr(caddr2), .crespcyc(cresp2),
    .cdata(cdata2), .memrdreqcyc(mreq2), .memrdaddr(maddr2), .memrdrespcyc(mresp2),
    .memrddata(mdata2), .dbg_state_o(st2)
  );

  mem_read_arbiter #(.NCLIENT(4)) u_dut4 (
    .clk(clk), .reset(reset), .creqcyc(creq4), .caddr(caddr4), .crespcyc(cresp4),
    .cdata(cdata4), .memrdreqcyc(mreq4), .memrdaddr(maddr4), .memrdrespcyc(mresp4),
    .memrddata(mdata4), .dbg_state_o(st4)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] A0  = 64'h1234_5678_9ABC_DEF7;
  localparam logic [63:0] A0E = 64'h1234_5678_9ABC_DEC0;
  localparam logic [63:0] A1  = 64'h0000_00FF_0000_107F;
  localparam logic [63:0] A1E = 64'h0000_00FF_0000_1040;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pat(input int k);
    pat = {16{32'hA500_0000 + 32'(k)}};
  endfunction

  function automatic logic [63:0] addr4(input int i);
    addr4 = 64'h4000_0000_0000_003F | (64'(i) << 12);
  endfunction

  function automatic logic [63:0] addr4e(input int i);
    addr4e = 64'h4000_0000_0000_0000 | (64'(i) << 12);
  endfunction

  // Called just after the grant edge: memory answers `lat` cycles after memrdreqcyc rose.
  task automatic serve2(input string tag, input int lat, input logic [63:0] exp_addr,
                        input logic [511:0] data, input logic [1:0] exp_pulse);
    for (int i = 1; i < lat; i++) begin
      step();
      check({tag, "_busy"}, {mreq2, st2, cresp2, maddr2}, {1'b1, S_BUSY, 2'b00, exp_addr});
    end
    mdata2 = data;
    mresp2 = 1'b1;
    step();
    mresp2 = 1'b0;
    check({tag, "_pulse"}, cresp2, exp_pulse);
    check({tag, "_cdata"}, cdata2, data);
    check({tag, "_resp"}, {mreq2, st2}, {1'b0, S_RESP});
  endtask

  task automatic serve4(input string tag, input int lat, input logic [511:0] data,
                        input logic [3:0] exp_pulse);
    for (int i = 1; i < lat; i++) begin
      step();
      check({tag, "_busy"}, {mreq4, st4, cresp4}, {1'b1, S_BUSY, 4'b0000});
    end
    mdata4 = data;
    mresp4 = 1'b1;
    step();
    mresp4 = 1'b0;
    check({tag, "_pulse"}, cresp4, exp_pulse);
    check({tag, "_cdata"}, cdata4, data);
  endtask

  initial begin
    int w;
    int first4;
    int second4;
    reset  = 1'b0;
    creq2  = '0;
    caddr2[0] = A0;
    caddr2[1] = A1;
    mresp2 = 1'b0;
    mdata2 = '0;
    creq4  = '0;
    for (int i = 0; i < 4; i++) caddr4[i] = addr4(i);
    mresp4 = 1'b0;
    mdata4 = '0;

    step();
    step();
    check("rst2_outs", {mreq2, maddr2, cresp2, st2}, '0);
    check("rst2_cdata", cdata2, '0);
    check("rst4_outs", {mreq4, maddr4, cresp4, st4}, '0);
    reset = 1'b1;
    step();
    check("idle_noreq", {mreq2, st2}, {1'b0, S_IDLE});

    // Client 0 alone, memory answers 5 cycles after the request rises.
    creq2 = 2'b01;
    step();
    check("r028_grant", {mreq2, st2, maddr2}, {1'b1, S_BUSY, A0E});
    serve2("r028", 5, A0E, pat(1), 2'b01);
    creq2 = 2'b00;
    step();
    check("r028_idle", {cresp2, st2, mreq2}, {2'b00, S_IDLE, 1'b0});
    check("r028_hold", cdata2, pat(1));

    // Stray completion in IDLE.
    mdata2 = '1;
    mresp2 = 1'b1;
    step();
    mresp2 = 1'b0;
    check("stray_outs", {cresp2, st2, mreq2}, {2'b00, S_IDLE, 1'b0});
    check("stray_cdata", cdata2, pat(1));

    // Minimum latency: completion one cycle after the request rises.
    creq2 = 2'b01;
    step();
    check("minlat_grant", {mreq2, maddr2}, {1'b1, A0E});
    serve2("minlat", 1, A0E, pat(2), 2'b01);
    creq2 = 2'b00;
    step();

    // Client 1 drops its request one cycle after the grant.
    creq2 = 2'b10;
    step();
    check("drop_grant", {mreq2, maddr2}, {1'b1, A1E});
    creq2 = 2'b00;
    serve2("drop", 3, A1E, pat(3), 2'b10);
    step();
    check("drop_idle", {cresp2, st2}, {2'b00, S_IDLE});
    step();
    check("drop_stay", {cresp2, st2, mreq2}, {2'b00, S_IDLE, 1'b0});

    // Both clients held continuously.
    creq2 = 2'b11;
    for (int g = 0; g < 4; g++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
      w = g % 2;
`else
      w = 0;
`endif
      step();
      check("both_grant", maddr2, (w == 0) ? A0E : A1E);
      serve2("both", 2, (w == 0) ? A0E : A1E, pat(10 + g), (w == 0) ? 2'b01 : 2'b10);
      step();
      check("both_idle", {cresp2, st2}, {2'b00, S_IDLE});
    end
    creq2 = 2'b00;
    step();

    // Reset in the middle of BUSY, then a late completion.
    creq2 = 2'b01;
    step();
    step();
    check("rstbusy_pre", {mreq2, st2}, {1'b1, S_BUSY});
    #2;
    reset = 1'b0;
    creq2 = 2'b00;
    #1;
    check("rstbusy_async", {mreq2, maddr2, cresp2, st2}, '0);
    check("rstbusy_cdata", cdata2, '0);
    step();
    reset  = 1'b1;
    mdata2 = '1;
    mresp2 = 1'b1;
    step();
    mresp2 = 1'b0;
    check("late_resp", {cresp2, st2, mreq2}, {2'b00, S_IDLE, 1'b0});
    check("late_cdata", cdata2, '0);
    step();
    check("late_nopulse", cresp2, 2'b00);
    // First arbitration after reset favours client 0.
    creq2 = 2'b11;
    step();
    check("post_rst_grant", {mreq2, maddr2}, {1'b1, A0E});
    serve2("post_rst", 2, A0E, pat(20), 2'b01);
    creq2 = 2'b00;
    step();

    // 4 clients: client 1 alone moves the pointer to 2, then clients 1 and 3 compete.
    creq4 = 4'b0010;
    step();
    check("c4_g1", {mreq4, maddr4}, {1'b1, addr4e(1)});
    serve4("c4_g1", 2, pat(30), 4'b0010);
    creq4 = 4'b0000;
    step();
`ifdef MEMARB_ROUND_ROBIN_EN
    first4  = 3;
    second4 = 1;
`else
    first4  = 1;
    second4 = 3;
`endif
    creq4 = 4'b1010;
    step();
    check("c4_first", {mreq4, maddr4}, {1'b1, addr4e(first4)});
    serve4("c4_first", 2, pat(31), 4'(1 << first4));
    creq4 = 4'(1 << second4);
    step();
    step();
    check("c4_second", {mreq4, maddr4}, {1'b1, addr4e(second4)});
    serve4("c4_second", 3, pat(32), 4'(1 << second4));
    creq4 = 4'b0000;
    step();
    check("c4_idle", {cresp4, st4, mreq4}, {4'b0000, S_IDLE, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter NCLIENT, default 2, number of read requesters (legal 2..4); client 0 = instruction cache, client 1 = data cache.
REQ-002 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-004 Port creqcyc, input, NCLIENT, per-client read request; held high until that client's respcyc pulse.
REQ-005 Port caddr, input, NCLIENT x 64, per-client block address; bits [5:0] ignored.
REQ-006 Port crespcyc, output, NCLIENT, per-client one-cycle response strobe.
REQ-007 Port cdata, output, 512 (bit order [0:511]), response block, broadcast to all clients.
REQ-008 Port memrdreqcyc, output, 1, request to the MuskbusReader.
REQ-009 Port memrdaddr, output, 64, 64-byte-aligned address to the MuskbusReader.
REQ-010 Port memrdrespcyc, input, 1, MuskbusReader completion strobe.
REQ-011 Port memrddata, input, 512 ([0:511]), MuskbusReader block data.

Function
REQ-012 State machine SHALL have states IDLE, BUSY and RESP; at most one memory read is outstanding.
REQ-013 IDLE, any creqcyc high at edge t: winner SHALL be registered, caddr[winner] latched with [5:0] forced to 0, state to BUSY; memrdreqcyc high from t+1.
REQ-014 IDLE, no creqcyc high: SHALL remain IDLE with memrdreqcyc low.
REQ-015 BUSY: memrdreqcyc SHALL stay high and memrdaddr stable until memrdrespcyc is sampled high.
REQ-016 BUSY and memrdrespcyc high at edge u: memrddata SHALL be registered into cdata, memrdreqcyc dropped, state to RESP; crespcyc[winner] high for exactly the cycle after u.
REQ-017 RESP: SHALL return to IDLE after one cycle; cdata SHALL hold its value until the next capture.
REQ-018 Only crespcyc[winner] SHALL pulse; all other crespcyc bits SHALL stay 0.
REQ-019 Winner dropping creqcyc during BUSY: transaction SHALL still complete and crespcyc[winner] SHALL still pulse.
REQ-020 memrdrespcyc in IDLE or RESP SHALL be ignored, with no state or output change.
REQ-021 Client whose creqcyc is still high in the IDLE cycle after its pulse SHALL be treated as a new request.
REQ-022 Minimum latency from creqcyc to crespcyc SHALL be 2 cycles plus the memory latency (memrdrespcyc one cycle after memrdreqcyc rises gives crespcyc at t+3).

Reset
REQ-023 reset low SHALL immediately force state IDLE, memrdreqcyc 0, memrdaddr 0, crespcyc all 0, cdata 0, priority pointer 0.
REQ-024 Reset during BUSY SHALL abandon the transaction; no crespcyc SHALL pulse for it, and a later memrdrespcyc SHALL be ignored per REQ-020.
REQ-025 First arbitration after reset release SHALL use pointer 0 (client 0 highest priority).

Configuration
REQ-026 Macro MEMARB_ROUND_ROBIN_EN defined: priority pointer SHALL advance to (winner+1) mod NCLIENT at each grant; search starts at the pointer, ascending index with wrap.
REQ-027 MEMARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; pointer logic SHALL be absent.

Verification
REQ-028 Client 0 only, caddr=0x1234_5678_9ABC_DEF7, memory answers 5 cycles after memrdreqcyc rises -> memrdaddr=0x1234_5678_9ABC_DEC0; crespcyc[0] single pulse; cdata=memrddata.
REQ-029 Both clients request at the same edge, held continuously, RR enabled, NCLIENT=2 -> grants 0,1,0,1; RR disabled -> grants 0,0,0 while client 0 stays high.
REQ-030 Stray memrdrespcyc in IDLE with memrddata all-ones -> no crespcyc, cdata unchanged, state IDLE.
REQ-031 reset pulsed low mid-BUSY, then memrdrespcyc after release -> outputs 0 within the reset cycle, no crespcyc pulse, next request granted normally.
REQ-032 Client 1 drops creqcyc one cycle after grant -> crespcyc[1] still pulses once; arbiter back in IDLE after RESP.
REQ-033 NCLIENT=4, RR enabled, clients 1 and 3 requesting, pointer at 2 -> client 3 wins, pointer becomes 0, client 1 wins next.
